// File: rtl/banner_blitter.sv
// banner_blitter: parametrised 1-bit bitmap renderer for the VGA plot port.
// A start pulse in IDLE latches the placement and mode inputs. The block then
// walks the bitmap row by row. Each row (sub-row when scaled) is fetched into
// a shift register, and one pixel per clock is streamed out as x/y/colour/plot.
// Pixels landing off-screen are clipped.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   start               draw request, honoured only when idle
//   x0, y0              top-left corner (latched on start)
//   opaque, cycle_en    background / colour-cycling mode (latched on start)
//   fg_colour, bg_colour fixed foreground and opaque-background colours
//   tick                frame pulse advancing the colour cycler
//   row_addr, row_data  bitmap row request and the row bits (MSB = leftmost)
//   x, y, colour, plot  registered pixel stream to the VGA adapter
//   busy, done          arbitration status; done is a one-cycle pulse
module banner_blitter #(
  parameter int unsigned BMP_W     = 116,
  parameter int unsigned BMP_H     = 14,
  parameter int unsigned SCALE     = 1,
  parameter int unsigned SCR_W     = 160,
  parameter int unsigned SCR_H     = 120,
  parameter int unsigned CYC_TICKS = 50
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       x0,
  input  logic [6:0]       y0,
  input  logic             opaque,
  input  logic             cycle_en,
  input  logic [2:0]       fg_colour,
  input  logic [2:0]       bg_colour,
  input  logic             tick,
  output logic [3:0]       row_addr,
  input  logic [BMP_W-1:0] row_data,
  output logic [7:0]       x,
  output logic [6:0]       y,
  output logic [2:0]       colour,
  output logic             plot,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NC  = BMP_W * SCALE;
  localparam int unsigned NSR = BMP_H * SCALE;
  localparam int unsigned CW  = (NC > 1) ? $clog2(NC) : 1;
  localparam int unsigned SRW = (NSR > 1) ? $clog2(NSR) : 1;
  localparam int unsigned RW  = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned TW  = (CYC_TICKS > 1) ? $clog2(CYC_TICKS) : 1;
  // Coordinate sums are kept wide enough that a large column count can never
  // wrap back on-screen before the clip compare.
  localparam int unsigned XW  = (CW + 1 > 9) ? CW + 1 : 9;
  localparam int unsigned YW  = (SRW + 1 > 8) ? SRW + 1 : 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       x0_q;
  logic [6:0]       y0_q;
  logic             opaque_q;
  logic             cycle_en_q;
  logic [SRW-1:0]   sr;
  logic [CW-1:0]    c;
  logic [RW-1:0]    rep;
  logic [BMP_W-1:0] shreg;
  logic [TW-1:0]    tick_cnt;
  logic [2:0]       cyc;

  logic             px_bit;
  logic [XW-1:0]    px_x;
  logic [YW-1:0]    px_y;
  logic             px_on;
  logic [2:0]       px_colour;

  // Row index follows the sub-row counter; with SCALE > 1 each bitmap row is
  // fetched SCALE times in a row.
  always_comb begin
    row_addr = 4'(32'(sr) / SCALE);
  end

  always_comb begin
    px_bit    = shreg[BMP_W-1];
    px_x      = XW'(x0_q) + XW'(c);
    px_y      = YW'(y0_q) + YW'(sr);
    px_on     = (px_bit | opaque_q) && (px_x < XW'(SCR_W)) && (px_y < YW'(SCR_H));
    px_colour = px_bit ? (cycle_en_q ? cyc : fg_colour) : bg_colour;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      opaque_q   <= 1'b0;
      cycle_en_q <= 1'b0;
      sr         <= '0;
      c          <= '0;
      rep        <= '0;
      shreg      <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x0_q       <= x0;
            y0_q       <= y0;
            opaque_q   <= opaque;
            cycle_en_q <= cycle_en;
            sr         <= '0;
            c          <= '0;
            busy       <= 1'b1;
            state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          shreg <= row_data;
          c     <= '0;
          rep   <= '0;
          state <= S_DRAW;
        end
        S_DRAW: begin
          plot <= px_on;
          // Coordinates and colour only move on a real plot so the VGA side
          // sees them hold between strobes.
          if (px_on) begin
            x      <= px_x[7:0];
            y      <= px_y[6:0];
            colour <= px_colour;
          end
          if (rep == RW'(SCALE - 1)) begin
            rep   <= '0;
            shreg <= shreg << 1;
          end else begin
            rep <= rep + RW'(1);
          end
          if (c == CW'(NC - 1)) begin
            if (sr == SRW'(NSR - 1)) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              sr    <= sr + SRW'(1);
              state <= S_FETCH;
            end
          end else begin
            c <= c + CW'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Colour cycler runs regardless of the draw state machine.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
      cyc      <= '0;
    end else if (tick) begin
      if (tick_cnt == TW'(CYC_TICKS - 1)) begin
        tick_cnt <= '0;
        cyc      <= cyc + 3'd1;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

endmodule
